// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_pkg
// Description : Shared constants and types for the system configuration
//               register bank: register indices, field defaults, the default
//               packed reset image and the bus-cycle decode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

  // Register indices consumed by the UART / clock-divider datapath
  localparam int REG_UART_CFG  = 2;
  localparam int REG_DIV_RATIO = 3;

  // Field defaults: UART_CFG [0] parity enable, [1] parity type, [6:2] prescale
  localparam logic [7:0] UART_CFG_DEF  = 8'h21;
  localparam logic [7:0] DIV_RATIO_DEF = 8'h08;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Packed reset image for the default 16 x 8 bank; reg i lives at [i*8 +: 8]
  localparam logic [DEF_DEPTH*DEF_WIDTH-1:0] DEFAULT_RST_VAL =
      ((DEF_DEPTH*DEF_WIDTH)'(DIV_RATIO_DEF) << (REG_DIV_RATIO*DEF_WIDTH)) |
      ((DEF_DEPTH*DEF_WIDTH)'(UART_CFG_DEF)  << (REG_UART_CFG*DEF_WIDTH));

  // Field view of the UART configuration register
  typedef struct packed {
    logic       rsvd;
    logic [4:0] prescale;
    logic       par_type;
    logic       par_en;
  } uart_cfg_t;

  // Outcome of one bus cycle, highest priority first
  typedef enum logic [2:0] {
    OP_IDLE     = 3'd0,
    OP_CONFLICT = 3'd1,
    OP_RANGE    = 3'd2,
    OP_RO       = 3'd3,
    OP_WRITE    = 3'd4,
    OP_READ     = 3'd5
  } bus_op_t;

endpackage
`default_nettype wire

// File: rtl/reg_chg_det.sv
`default_nettype none
// ============================================================================
// Module      : reg_chg_det
// Description : Per-tap change detector. Shadow copies of the exported
//               registers lag the live values by one edge; a tap flags a
//               change while live and shadow differ.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_chg_det #(
  parameter int                         WIDTH   = 8,
  parameter int                         NUM_TAP = 4,
  parameter logic [NUM_TAP*WIDTH-1:0]   RST_VAL = '0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_TAP*WIDTH-1:0] Taps,
  output logic [NUM_TAP-1:0]       Tap_Chg
);

  logic [NUM_TAP*WIDTH-1:0] r_shadow;

  // Shadow starts equal to the register reset image so reset load is not a change
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shadow <= RST_VAL;
    end else begin
      r_shadow <= Taps;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_TAP; gi++) begin : g_cmp
      assign Tap_Chg[gi] = (Taps[gi*WIDTH +: WIDTH] != r_shadow[gi*WIDTH +: WIDTH]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/cfg_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : cfg_reg_bank
// Description : System register bank between the command controller and the
//               UART / clock-divider datapath. Bus read/write port with error
//               reporting, per-register reset values, read-only mask, a
//               hardware status write port and continuously exported taps
//               with change pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_reg_bank
  import reg_bank_pkg::*;
#(
  parameter int                       WIDTH   = 8,
  parameter int                       DEPTH   = 16,
  parameter int                       ADDR    = 4,
  parameter int                       NUM_TAP = 4,
  parameter logic [DEPTH*WIDTH-1:0]   RST_VAL = (DEPTH*WIDTH)'(DEFAULT_RST_VAL),
  parameter logic [DEPTH-1:0]         RO_MASK = '0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WrEn,
  input  logic                     RdEn,
  input  logic [ADDR-1:0]          Address,
  input  logic [WIDTH-1:0]         WrData,
  input  logic                     HwWrEn,
  input  logic [ADDR-1:0]          HwAddr,
  input  logic [WIDTH-1:0]         HwData,
  output logic [WIDTH-1:0]         RdData,
  output logic                     RdData_VLD,
  output logic                     Err,
  output logic [NUM_TAP*WIDTH-1:0] Taps,
  output logic [NUM_TAP-1:0]       Tap_Chg
);

  // One extra bit so DEPTH == 2**ADDR still compares correctly
  localparam logic [ADDR:0]          c_DEPTH   = (ADDR+1)'(DEPTH);
  // Mask widened to the full address space; unused entries are never reached
  localparam logic [(2**ADDR)-1:0]   c_RO_FULL = (2**ADDR)'(RO_MASK);

  logic [WIDTH-1:0]         r_reg_arr [DEPTH];
  logic [WIDTH-1:0]         r_rd_data;
  logic                     r_rd_vld;
  logic                     r_err;
  bus_op_t                  w_op;
  logic                     w_addr_ok;
  logic                     w_hw_ok;
  logic [WIDTH-1:0]         w_rd_val;
  logic [NUM_TAP*WIDTH-1:0] w_taps;

  assign w_addr_ok = ({1'b0, Address} < c_DEPTH);
  assign w_hw_ok   = HwWrEn && ({1'b0, HwAddr} < c_DEPTH);

  // Classify this cycle's bus request in priority order
  always_comb begin
    w_op = OP_IDLE;
    if (WrEn && RdEn) begin
      w_op = OP_CONFLICT;
    end else if ((WrEn || RdEn) && !w_addr_ok) begin
      w_op = OP_RANGE;
    end else if (WrEn && c_RO_FULL[Address]) begin
      w_op = OP_RO;
    end else if (WrEn) begin
      w_op = OP_WRITE;
    end else if (RdEn) begin
      w_op = OP_READ;
    end
  end

  // Read mux over the implemented registers only
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (Address == ADDR'(i)) begin
        w_rd_val = r_reg_arr[i];
      end
    end
  end

  // Register array: hardware write takes precedence over a bus write to the same entry
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_reg_arr[i] <= RST_VAL[i*WIDTH +: WIDTH];
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_hw_ok && (HwAddr == ADDR'(i))) begin
          r_reg_arr[i] <= HwData;
        end else if ((w_op == OP_WRITE) && (Address == ADDR'(i))) begin
          r_reg_arr[i] <= WrData;
        end
      end
    end
  end

  // Registered bus response: read data, valid pulse and error pulse
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rd_vld <= (w_op == OP_READ);
      r_err    <= (w_op == OP_CONFLICT) || (w_op == OP_RANGE) || (w_op == OP_RO);
      if (w_op == OP_READ) begin
        r_rd_data <= w_rd_val;
      end else if ((w_op == OP_RANGE) && RdEn) begin
        r_rd_data <= '0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_TAP; gi++) begin : g_tap
      assign w_taps[gi*WIDTH +: WIDTH] = r_reg_arr[gi];
    end
  endgenerate

  reg_chg_det #(
    .WIDTH   (WIDTH),
    .NUM_TAP (NUM_TAP),
    .RST_VAL (RST_VAL[NUM_TAP*WIDTH-1:0])
  ) u_chg_det (
    .CLK     (CLK),
    .RST     (RST),
    .Taps    (w_taps),
    .Tap_Chg (Tap_Chg)
  );

  assign RdData     = r_rd_data;
  assign RdData_VLD = r_rd_vld;
  assign Err        = r_err;
  assign Taps       = w_taps;

endmodule
`default_nettype wire
